// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle (no ID/user fields) shared by initiators and responders.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) ();
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite responder for a bank of 64-bit registers with per-register write pulses.
// Define AXI_LITE_REG_SLAVE_ERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi_lite_reg_slave #(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  AXI_LITE.Slave                 axi_slave_port,
  output logic [NUM_REGS*64-1:0] reg_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam logic [31:0] BANK_BYTES = 32'(NUM_REGS * 8);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
`ifdef AXI_LITE_REG_SLAVE_ERR_RESP_EN
  localparam logic [1:0]  RESP_OOR   = 2'b10;
`else
  localparam logic [1:0]  RESP_OOR   = 2'b00;
`endif

  logic [63:0]         regs [NUM_REGS];

  logic                aw_full;
  logic [31:0]         aw_addr_q;
  logic                w_full;
  logic [63:0]         w_data_q;
  logic [7:0]          w_strb_q;

  logic                b_valid_q;
  logic [1:0]          b_resp_q;
  logic                r_valid_q;
  logic [63:0]         r_data_q;
  logic [1:0]          r_resp_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic                aw_fire;
  logic                w_fire;
  logic                ar_fire;
  logic                commit;

  logic [32:0]         wr_diff;
  logic [32:0]         rd_diff;
  logic                wr_hit;
  logic                rd_hit;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic                unused_bits;

  // The extra top bit of the difference is the borrow, i.e. addr < BASE_ADDR.
  assign wr_diff = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
  assign rd_diff = {1'b0, axi_slave_port.ar_addr} - {1'b0, BASE_ADDR};
  assign wr_hit  = !wr_diff[32] && (wr_diff[31:0] < BANK_BYTES);
  assign rd_hit  = !rd_diff[32] && (rd_diff[31:0] < BANK_BYTES);
  assign wr_idx  = wr_diff[3 +: IDX_W];
  assign rd_idx  = rd_diff[3 +: IDX_W];

  assign aw_fire = axi_slave_port.aw_valid && !aw_full;
  assign w_fire  = axi_slave_port.w_valid && !w_full;
  assign ar_fire = axi_slave_port.ar_valid && !r_valid_q;
  assign commit  = aw_full && w_full && !b_valid_q;

  assign axi_slave_port.aw_ready = !aw_full;
  assign axi_slave_port.w_ready  = !w_full;
  assign axi_slave_port.b_valid  = b_valid_q;
  assign axi_slave_port.b_resp   = b_resp_q;
  assign axi_slave_port.ar_ready = !r_valid_q;
  assign axi_slave_port.r_valid  = r_valid_q;
  assign axi_slave_port.r_data   = r_data_q;
  assign axi_slave_port.r_resp   = r_resp_q;

  assign wr_pulse_o = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_o[64*i +: 64] = regs[i];
  end

  assign unused_bits = ^{axi_slave_port.aw_prot, axi_slave_port.ar_prot, wr_diff, rd_diff};

  // AW and W are captured independently; a full buffer stays full until its commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_fire) begin
        aw_full   <= 1'b1;
        aw_addr_q <= axi_slave_port.aw_addr;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_fire) begin
        w_full   <= 1'b1;
        w_data_q <= axi_slave_port.w_data;
        w_strb_q <= axi_slave_port.w_strb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // Register bank update and the one-cycle pulse that follows each in-range commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit && wr_hit) begin
        for (int k = 0; k < 8; k++) begin
          if (w_strb_q[k]) begin
            regs[wr_idx][8*k +: 8] <= w_data_q[8*k +: 8];
          end
        end
        wr_pulse_q[wr_idx] <= 1'b1;
      end
    end
  end

  // A pending B response blocks the next commit, so buffers may refill meanwhile.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      if (commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_hit ? RESP_OKAY : RESP_OOR;
      end else if (b_valid_q && axi_slave_port.b_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Read data is sampled from the pre-commit register value on a same-edge collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_hit ? regs[rd_idx] : 64'h0;
        r_resp_q  <= rd_hit ? RESP_OKAY : RESP_OOR;
      end else if (r_valid_q && axi_slave_port.r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

endmodule
